// File: rtl/data_mem_pkg.sv
// Shared widths and types for the processor data memory.
// Default geometry: 64 words of 32 bits.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 6;
    localparam int DEPTH  = 1 << IDX_W;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/data_mem_array.sv
// 2^r x n register array with a synchronous clear, one write port and an
// asynchronous read port. Clear overrides write.
module data_mem_array
    import dmem_pkg::*;
#(
    parameter int n = DATA_W,
    parameter int r = IDX_W
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         write_en,
    input  logic [r-1:0] write_idx,
    input  logic [n-1:0] write_data,
    input  logic [r-1:0] read_idx,
    output logic [n-1:0] read_data
);

    localparam int WORDS = 1 << r;

    logic [n-1:0] mem_reg [WORDS];

    // Built from flops rather than block RAM: the read has to be combinational
    // and every word has to clear in a single cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (write_en) begin
            mem_reg[write_idx] <= write_data;
        end
    end

    assign read_data = mem_reg[read_idx];

endmodule

// File: rtl/data_mem.sv
// Single-port word-addressed data memory. Only the low r address bits are
// decoded, so higher addresses alias onto the array.
module data_mem
    import dmem_pkg::*;
#(
    parameter int n = DATA_W,
    parameter int r = IDX_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         writeEnable,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] writeData,
    output logic [n-1:0] readData
);

    logic [r-1:0]   word_idx;
    logic           store_en;
    logic [n-r-1:0] unused_addr_hi;

    assign word_idx       = addr[r-1:0];
    assign unused_addr_hi = addr[n-1:r];

    // Reset wins over a store on the same edge, so that store is dropped.
    assign store_en = writeEnable & ~reset;

    data_mem_array #(
        .n(n),
        .r(r)
    ) u_array (
        .clk       (clk),
        .clear     (reset),
        .write_en  (store_en),
        .write_idx (word_idx),
        .write_data(writeData),
        .read_idx  (word_idx),
        .read_data (readData)
    );

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed cases followed by random traffic
// compared against a simple array model of the memory.
module tb_data_mem;
    import dmem_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  writeEnable;
    word_t addr;
    word_t writeData;
    word_t readData;

    int    checks = 0;
    int    errors = 0;
    word_t model [DEPTH];

    always #5 clk = ~clk;

    data_mem #(
        .n(DATA_W),
        .r(IDX_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .writeEnable(writeEnable),
        .addr       (addr),
        .writeData  (writeData),
        .readData   (readData)
    );

    task automatic check_read(input string tag, input word_t expected);
        #1;
        checks++;
        assert (readData === expected) else begin
            errors++;
            $error("FAIL %s: addr=%h readData=%h expected=%h", tag, addr, readData, expected);
        end
        $display("check %-14s addr=%h readData=%h expected=%h", tag, addr, readData, expected);
    endtask

    // Apply the memory rules to the model for the coming edge, then take the edge.
    task automatic edge_step();
        if (reset === 1'b1) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (writeEnable === 1'b1) begin
            model[addr % DEPTH] = writeData;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input word_t a, input word_t d);
        addr        = a;
        writeData   = d;
        writeEnable = 1'b1;
        edge_step();
        writeEnable = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        writeEnable = 1'b0;
        addr        = '0;
        writeData   = '0;
        @(negedge clk);
        edge_step();
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            addr = word_t'(i);
            check_read("reset_sweep", 32'h0000_0000);
        end

        write_word(32'h15, 32'hDEAD_BEEF);
        check_read("store_15", 32'hDEAD_BEEF);
        write_word(32'h2A, 32'hACAC_ACAC);
        check_read("store_2a", 32'hACAC_ACAC);
        write_word(32'h3F, 32'hBCBC_BCBC);
        check_read("store_3f", 32'hBCBC_BCBC);
        addr = 32'h15;
        check_read("revisit_15", 32'hDEAD_BEEF);

        addr      = 32'h2A;
        writeData = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            edge_step();
            check_read("hold_2a", 32'hACAC_ACAC);
        end

        addr = 32'h55;
        check_read("alias_55", 32'hDEAD_BEEF);
        write_word(32'h7F, 32'h1111_1111);
        addr = 32'h3F;
        check_read("alias_7f_3f", 32'h1111_1111);

        reset       = 1'b1;
        writeEnable = 1'b1;
        addr        = 32'h15;
        writeData   = 32'hFFFF_FFFF;
        edge_step();
        reset       = 1'b0;
        writeEnable = 1'b0;
        check_read("rst_prio_15", 32'h0000_0000);
        for (int i = 0; i < DEPTH; i++) begin
            addr = word_t'(i);
            check_read("rst_prio_all", 32'h0000_0000);
        end

        addr        = 32'h2A;
        writeEnable = 1'b1;
        writeData   = 32'hCAFE_F00D;
        check_read("rdw_before", 32'h0000_0000);
        edge_step();
        writeEnable = 1'b0;
        check_read("rdw_after", 32'hCAFE_F00D);

        // Random traffic: mostly stores, occasional reset, full-width addresses.
        for (int i = 0; i < 300; i++) begin
            reset       = ($urandom_range(0, 39) == 0);
            writeEnable = ($urandom_range(0, 2) != 0);
            addr        = ($urandom_range(0, 3) == 0) ? word_t'($urandom) : word_t'($urandom_range(0, 255));
            writeData   = word_t'($urandom);
            check_read("rand_pre", model[addr % DEPTH]);
            edge_step();
            reset       = 1'b0;
            writeEnable = 1'b0;
            check_read("rand_post", model[addr % DEPTH]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
